pipe_reg: RTL

PIPE_REG -- requirements
Module: pipe_reg

---
 rtl/pipe_pkg.sv | 11 +
 rtl/pipe_stage.sv | 46 ++++
 rtl/pipe_reg.sv | 88 ++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and width helpers for the pipe_reg register pipeline.
package pipe_pkg;

    localparam int unsigned DEFAULT_RESET_VAL = 0;

    // Bits needed to count 0..depth inclusive.
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline stage: a valid bit plus data word with advance enable and valid clear.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEFAULT_RESET_VAL)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Clear drops the valid bit only; the data word keeps its last value.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clr) begin
            valid_d = 1'b0;
        end else if (en) begin
            valid_d = in_valid;
            data_d  = in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= RESET_VAL;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/pipe_reg.sv
// DEPTH-stage enable/flush register pipeline with registered occupancy, full and empty.
module pipe_reg
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEFAULT_RESET_VAL),
    localparam int unsigned     OCC_W     = occ_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy,
    output logic             full,
    output logic             empty
);

    logic [DEPTH-1:0] stage_valid;
    logic [WIDTH-1:0] stage_data [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             prev_valid;
        logic [WIDTH-1:0] prev_data;

        if (k == 0) begin : g_head
            assign prev_valid = in_valid;
            assign prev_data  = in_data;
        end else begin : g_chain
            assign prev_valid = stage_valid[k-1];
            assign prev_data  = stage_data[k-1];
        end

        pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .en        (en),
            .clr       (flush),
            .in_valid  (prev_valid),
            .in_data   (prev_data),
            .out_valid (stage_valid[k]),
            .out_data  (stage_data[k])
        );
    end

    assign out_valid = stage_valid[DEPTH-1];
    assign out_data  = stage_data[DEPTH-1];

    logic [OCC_W-1:0] occ_q, occ_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;

    // Count tracks the valid bits after the shift: one enters at stage 0, one leaves from the tail.
    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (en) begin
            occ_d = occ_q + OCC_W'(in_valid) - OCC_W'(out_valid);
        end
        full_d  = (occ_d == OCC_W'(DEPTH));
        empty_d = (occ_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            occ_q   <= occ_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    assign occupancy = occ_q;
    assign full      = full_q;
    assign empty     = empty_q;

endmodule
